uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
8N1 UART receiver, the downstream consumer of the serial line driven by the team's baud-rate transmit stage.
- Synchronises the asynchronous rx line and detects the start bit.
- Samples each bit at mid-bit using a clock-derived baud counter with the same divisor scheme as the transmitter (freq/baud).
- Presents received bytes on a valid/ack handshake and reports framing and overrun errors.

Parameters:
freq, 12000000, system clock frequency in Hz
baud, 9600, line bit rate
lim, freq/baud (1250), clocks per bit; counter width = clog2(lim)
half, lim/2 (625), clocks from start detection to start-bit mid-sample

Ports:
clk  input  1  system clock, all state on posedge
nrst  input  1  asynchronous active-low reset
rx  input  1  serial line, idle high, asynchronous to clk
rx_data  output  8  last good received byte
rx_valid  output  1  rx_data holds an unconsumed byte
rx_ack  input  1  consumer accepts rx_data
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  sticky: byte completed while rx_valid still set
busy  output  1  high in every state except IDLE
bit_count  output  4  data bits received in current frame (0..8)

Behaviour:
- Reset: one clock, asynchronous and active-low (nrst), applied asynchronously and released synchronously to clk.
- Reset values: state=IDLE, counter=0, bit_count=0, rx_data=8'h00, rx_valid=0, frame_err=0, overrun=0, busy=0, both synchroniser flops=1.
- Reset mid-frame aborts the frame; partially shifted data is discarded.
- Synchroniser: two flops, rx -> s1 -> rx_s. Only rx_s is used internally.
- IDLE: when rx_s==0, go to START with counter=0.
- START: counter increments each clock. When counter==half-1, sample rx_s:
  - rx_s==0: go to DATA, counter=0, bit_count=0.
  - rx_s==1: glitch; return to IDLE with no flags.
- DATA: when counter==lim-1, shift rx_s into the shift register LSB-first (bit i -> data[i]), bit_count+1, counter=0. After the 8th bit (bit_count becomes 8), go to STOP.
- STOP: when counter==lim-1, sample rx_s:
  - rx_s==1: rx_data<=shift, rx_valid<=1, go to IDLE.
  - rx_s==0: frame_err pulses for 1 cycle, rx_data/rx_valid unchanged, go to WAIT_HIGH.
- WAIT_HIGH: stay until rx_s==1, then go to IDLE. This prevents a break condition from retriggering.
- Timing, with edge 0 = first clk edge at which s1 captures rx=0 (defaults):
  - start sampled at edge 627;
  - data bit i sampled at edge 627+1250*(i+1);
  - stop sampled at edge 11877;
  - rx_valid is 1 after edge 11877.
- Handshake:
  - rx_ack while rx_valid=1 clears rx_valid on the next edge.
  - rx_ack while rx_valid=0 is ignored.
- Overrun: a good stop while rx_valid=1 and rx_ack=0 overwrites rx_data, keeps rx_valid=1 and sets overrun=1.
- Simultaneous good stop and rx_ack: the new byte wins, rx_valid stays 1 and overrun is not set.
- overrun clears on any rx_ack that is not coincident with a new overrun event.
- bit_count holds 8 through STOP and resets to 0 on entering START.
- The counter never exceeds lim-1; no other wrap condition exists.
- A new start bit is accepted on the first IDLE cycle after a good stop, with back-to-back frames and no extra idle required.

Test Plan:
- Reset: hold nrst=0 with rx toggling -> all outputs at reset values. Release -> rx_valid=0 until a full frame arrives.
- Drive 0x54 (line 0,0,0,1,0,1,0,1,0,1) at 1250 clk/bit -> rx_data=8'h54 and rx_valid rises exactly 11877 edges after the start edge; frame_err=0.
- 300-clock low glitch on idle line -> no rx_valid, no frame_err, busy returns to 0 by edge 630.
- Frame 0xA5 with stop bit held low for 2 bit times -> frame_err single pulse, rx_valid=0. Module stays in WAIT_HIGH until the line goes high, then a following 0x3C is received correctly.
- Two back-to-back frames 0x11, 0x22 with no ack -> rx_data=8'h22, rx_valid=1, overrun=1. Then rx_ack for 1 cycle -> rx_valid=0, overrun=0.
- nrst pulsed low at data bit 4 of 0xFF -> immediate reset values. A subsequent 0x81 is received intact with no error flags.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit sampling from a
// freq/baud clock divider, valid/ack output handshake, and framing and
// overrun error reporting.
module uart_rx #(
    parameter int freq = 12000000,
    parameter int baud = 9600
) (
    input  logic       clk,
    input  logic       nrst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ack,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy,
    output logic [3:0] bit_count
);

    localparam int lim  = freq / baud;
    localparam int half = lim / 2;
    localparam int cw   = $clog2(lim);

    localparam logic [cw-1:0] cnt_last = cw'(lim - 1);
    localparam logic [cw-1:0] cnt_mid  = cw'(half - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_t;

    state_t        state, state_n;
    logic          s1, rx_s;
    logic [cw-1:0] cnt, cnt_n;
    logic [3:0]    bcnt, bcnt_n;
    logic [7:0]    shift, shift_n;
    logic          good_stop, bad_stop;

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            s1   <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            s1   <= rx;
            rx_s <= s1;
        end
    end

    // State register.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state, bit-timer, bit counter and shifter control.
    always_comb begin
        state_n   = state;
        cnt_n     = cnt + 1'b1;
        bcnt_n    = bcnt;
        shift_n   = shift;
        good_stop = 1'b0;
        bad_stop  = 1'b0;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                    bcnt_n  = 4'd0;
                end
            end
            START: begin
                if (cnt == cnt_mid) begin
                    cnt_n  = '0;
                    bcnt_n = 4'd0;
                    // A start bit that has gone high again by mid-bit is a glitch.
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == cnt_last) begin
                    cnt_n   = '0;
                    shift_n = {rx_s, shift[7:1]};
                    bcnt_n  = bcnt + 4'd1;
                    if (bcnt == 4'd7) state_n = STOP;
                end
            end
            STOP: begin
                if (cnt == cnt_last) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        good_stop = 1'b1;
                        state_n   = IDLE;
                    end else begin
                        bad_stop = 1'b1;
                        state_n  = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // Hold off until the line releases so a break cannot retrigger.
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    // Datapath registers driven by the next-state logic.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt   <= '0;
            bcnt  <= 4'd0;
            shift <= 8'h00;
        end else begin
            cnt   <= cnt_n;
            bcnt  <= bcnt_n;
            shift <= shift_n;
        end
    end

    // Output holding register, handshake and error flags.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            rx_data   <= 8'h00;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= bad_stop;
            if (good_stop) begin
                rx_data  <= shift;
                rx_valid <= 1'b1;
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
            end
            // An ack in the same cycle as the new byte means the old one was taken.
            if (good_stop && rx_valid && !rx_ack) overrun <= 1'b1;
            else if (rx_ack)                      overrun <= 1'b0;
        end
    end

    assign busy      = (state != IDLE);
    assign bit_count = bcnt;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: expected bytes go into a scoreboard queue as
// frames are driven and are popped when the receiver presents a byte.
// Line timing is scaled down (125 clocks per bit) to keep the run short;
// all edge expectations are derived from lim/half.
module tb_uart_rx;

    localparam int F        = 1200000;
    localparam int B        = 9600;
    localparam int LIM      = F / B;
    localparam int HALF     = LIM / 2;
    localparam int STOP_EDGE = HALF + 2 + 9 * LIM;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
    logic [3:0] bit_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    int fe_cnt = 0;
    logic [7:0] exp_q[$];

    uart_rx #(.freq(F), .baud(B)) dut (
        .clk(clk), .nrst(nrst), .rx(rx),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ack(rx_ack),
        .frame_err(frame_err), .overrun(overrun),
        .busy(busy), .bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Posedge counter: value after an edge is that edge's number.
    always @(posedge clk) cyc <= cyc + 1;

    // Count cycles with frame_err high (sampled at the edge, so race-free).
    always @(posedge clk) if (nrst && frame_err === 1'b1) fe_cnt <= fe_cnt + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_pop(input string tag);
        logic [7:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s: observed %0h expected <scoreboard empty>", tag, rx_data);
        end else begin
            e = exp_q.pop_front();
            check(tag, rx_data, e);
        end
    endtask

    // Hold the line at v for one bit time; entered and left at #1 after posedge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (LIM) @(posedge clk);
        #1;
    endtask

    // Start + 8 data bits, then line high; t0 = edge where s1 captures the start.
    task automatic send_data(input logic [7:0] d, output int t0);
        @(posedge clk); #1;
        t0 = cyc + 1;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        rx = 1'b1;
    endtask

    task automatic wait_valid(input int bound, output int at);
        at = -1;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (rx_valid === 1'b1) begin
                at = cyc;
                break;
            end
        end
    endtask

    task automatic pulse_ack();
        @(posedge clk); #1 rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int t0, at, fe0;

        // Reset held with rx toggling.
        repeat (6) begin @(posedge clk); #1 rx = ~rx; end
        @(negedge clk);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 1'b0);
        check("rst_frame_err", frame_err, 1'b0);
        check("rst_overrun", overrun, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_bit_count", bit_count, 4'd0);
        rx = 1'b1;
        @(posedge clk); #1 nrst = 1'b1;
        repeat (5) @(negedge clk);
        check("post_rst_valid", rx_valid, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        // 0x54: exact latency from start edge to rx_valid.
        exp_q.push_back(8'h54);
        send_data(8'h54, t0);
        wait_valid(2 * LIM, at);
        check("b54_latency", at - t0, STOP_EDGE);
        check_pop("b54_data");
        check("b54_busy", busy, 1'b0);
        check("b54_bit_count", bit_count, 4'd8);
        check("b54_frame_err_cnt", fe_cnt, 0);
        check("b54_overrun", overrun, 1'b0);
        pulse_ack();
        check("b54_ack_valid", rx_valid, 1'b0);
        pulse_ack();
        check("idle_ack_ignored", rx_valid, 1'b0);

        // Short low glitch on an idle line.
        repeat (20) @(posedge clk); #1;
        t0 = cyc + 1;
        rx = 1'b0;
        repeat (LIM * 24 / 100) @(posedge clk);
        #1 rx = 1'b1;
        check("glitch_busy_in", busy, 1'b1);
        while (cyc < t0 + HALF + 5) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_out", busy, 1'b0);
        check("glitch_valid", rx_valid, 1'b0);
        check("glitch_fe_cnt", fe_cnt, 0);

        // 0xA5 with stop held low for two bit times.
        repeat (20) @(posedge clk);
        fe0 = fe_cnt;
        send_data(8'hA5, t0);
        rx = 1'b0;
        repeat (2 * LIM) @(posedge clk);
        #1;
        check("a5_fe_pulses", fe_cnt - fe0, 1);
        check("a5_valid", rx_valid, 1'b0);
        check("a5_data_kept", rx_data, 8'h54);
        check("a5_wait_high_busy", busy, 1'b1);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("a5_release_busy", busy, 1'b0);
        exp_q.push_back(8'h3C);
        send_data(8'h3C, t0);
        wait_valid(2 * LIM, at);
        check("b3c_latency", at - t0, STOP_EDGE);
        check_pop("b3c_data");
        check("b3c_fe_cnt", fe_cnt - fe0, 1);
        pulse_ack();

        // Back-to-back 0x11, 0x22 with no ack -> overrun.
        exp_q.push_back(8'h11);
        send_data(8'h11, t0);
        drive_bit(1'b1);
        check_pop("b11_data");
        check("b11_valid", rx_valid, 1'b1);
        check("b11_overrun", overrun, 1'b0);
        exp_q.push_back(8'h22);
        send_data(8'h22, t0);
        drive_bit(1'b1);
        check_pop("b22_data");
        check("b22_valid", rx_valid, 1'b1);
        check("b22_overrun", overrun, 1'b1);
        pulse_ack();
        check("ovr_ack_valid", rx_valid, 1'b0);
        check("ovr_ack_overrun", overrun, 1'b0);

        // Ack coincident with a good stop: new byte wins, no overrun.
        exp_q.push_back(8'h33);
        send_data(8'h33, t0);
        drive_bit(1'b1);
        check_pop("b33_data");
        exp_q.push_back(8'h5A);
        send_data(8'h5A, t0);
        while (cyc < t0 + STOP_EDGE - 1) begin @(posedge clk); #1; end
        rx_ack = 1'b1;
        @(posedge clk); #1 rx_ack = 1'b0;
        @(negedge clk);
        check_pop("b5a_data");
        check("b5a_valid", rx_valid, 1'b1);
        check("b5a_overrun", overrun, 1'b0);
        pulse_ack();

        // Reset during data bit 4 of 0xFF.
        repeat (10) @(posedge clk); #1;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (LIM / 2) @(posedge clk);
        #1;
        check("ff_bit_count_mid", bit_count, 4'd4);
        nrst = 1'b0;
        #1;
        check("ff_rst_busy", busy, 1'b0);
        check("ff_rst_bit_count", bit_count, 4'd0);
        check("ff_rst_data", rx_data, 8'h00);
        check("ff_rst_valid", rx_valid, 1'b0);
        @(posedge clk); #1 nrst = 1'b1;
        repeat (5 * LIM) @(posedge clk);
        fe0 = fe_cnt;
        exp_q.push_back(8'h81);
        send_data(8'h81, t0);
        wait_valid(2 * LIM, at);
        check("b81_latency", at - t0, STOP_EDGE);
        check_pop("b81_data");
        check("b81_overrun", overrun, 1'b0);
        check("b81_fe_cnt", fe_cnt - fe0, 0);
        check("sb_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
